mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/liang_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/liang_pkg.sv
// Shared constants and types for the memory arbiter slice.
package liang_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IFU_RD,
    ARB_LSU_RD,
    ARB_LSU_WR
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one AXI-Lite slave arbiter.
// Fixed priority: LSU write > LSU read > IFU read, one grant at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH = liang_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = liang_pkg::DATA_WIDTH,
  parameter int STRB_WIDTH = liang_pkg::STRB_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // IFU read
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  output logic                  ifu_rvalid_o,
  input  logic                  ifu_rready_i,
  // LSU read
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  input  logic                  lsu_rready_i,
  // LSU write
  input  logic [ADDR_WIDTH-1:0] lsu_awaddr_i,
  input  logic                  lsu_awvalid_i,
  output logic                  lsu_awready_o,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [STRB_WIDTH-1:0] lsu_wstrb_i,
  input  logic                  lsu_wvalid_i,
  output logic                  lsu_wready_o,
  output logic [1:0]            lsu_bresp_o,
  output logic                  lsu_bvalid_o,
  input  logic                  lsu_bready_i,
  // slave side
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_rready_o,
  output logic [ADDR_WIDTH-1:0] mem_awaddr_o,
  output logic                  mem_awvalid_o,
  input  logic                  mem_awready_i,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [STRB_WIDTH-1:0] mem_wstrb_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  input  logic [1:0]            mem_bresp_i,
  input  logic                  mem_bvalid_i,
  output logic                  mem_bready_o
);
  import liang_pkg::*;

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Done flags stop a master that keeps its valid high from issuing a
  // second address/data beat within the same grant.
  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ARB_IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (lsu_awvalid_i || lsu_wvalid_i) state_d = ARB_LSU_WR;
        else if (lsu_arvalid_i)            state_d = ARB_LSU_RD;
        else if (ifu_arvalid_i)            state_d = ARB_IFU_RD;
      end
      ARB_IFU_RD, ARB_LSU_RD: begin
        if (mem_arvalid_o && mem_arready_i) ar_done_d = 1'b1;
        if (mem_rvalid_i && mem_rready_o) begin
          state_d   = ARB_IDLE;
          ar_done_d = 1'b0;
        end
      end
      ARB_LSU_WR: begin
        if (mem_awvalid_o && mem_awready_i) aw_done_d = 1'b1;
        if (mem_wvalid_o && mem_wready_i)   w_done_d  = 1'b1;
        if (mem_bvalid_i && mem_bready_o) begin
          state_d   = ARB_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign ifu_rdata_o = mem_rdata_i;
  assign lsu_rdata_o = mem_rdata_i;

  always_comb begin
    ifu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    lsu_arready_o = 1'b0;
    lsu_rvalid_o  = 1'b0;
    lsu_awready_o = 1'b0;
    lsu_wready_o  = 1'b0;
    lsu_bvalid_o  = 1'b0;
    lsu_bresp_o   = mem_bresp_i;
    mem_araddr_o  = lsu_araddr_i;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    mem_awaddr_o  = lsu_awaddr_i;
    mem_awvalid_o = 1'b0;
    mem_wdata_o   = lsu_wdata_i;
    mem_wstrb_o   = lsu_wstrb_i;
    mem_wvalid_o  = 1'b0;
    mem_bready_o  = 1'b0;
    case (state_q)
      ARB_IFU_RD: begin
        mem_araddr_o  = ifu_araddr_i;
        mem_arvalid_o = ifu_arvalid_i && !ar_done_q;
        ifu_arready_o = mem_arready_i && !ar_done_q;
        ifu_rvalid_o  = mem_rvalid_i;
        mem_rready_o  = ifu_rready_i;
      end
      ARB_LSU_RD: begin
        mem_arvalid_o = lsu_arvalid_i && !ar_done_q;
        lsu_arready_o = mem_arready_i && !ar_done_q;
        lsu_rvalid_o  = mem_rvalid_i;
        mem_rready_o  = lsu_rready_i;
      end
      ARB_LSU_WR: begin
        mem_awvalid_o = lsu_awvalid_i && !aw_done_q;
        lsu_awready_o = mem_awready_i && !aw_done_q;
        mem_wvalid_o  = lsu_wvalid_i && !w_done_q;
        lsu_wready_o  = mem_wready_i && !w_done_q;
        lsu_bvalid_o  = mem_bvalid_i;
        mem_bready_o  = lsu_bready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration table plus multi-cycle sequences.
module tb_mem_arbiter;

  localparam logic [31:0] IFU_A = 32'h8000_0000;
  localparam logic [31:0] LSU_A = 32'h8000_1004;
  localparam logic [31:0] WR_A  = 32'h8000_2000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ifu_araddr_i, lsu_araddr_i, lsu_awaddr_i, lsu_wdata_i, mem_rdata_i;
  logic        ifu_arvalid_i, ifu_rready_i, lsu_arvalid_i, lsu_rready_i;
  logic        lsu_awvalid_i, lsu_wvalid_i, lsu_bready_i;
  logic [3:0]  lsu_wstrb_i;
  logic        mem_arready_i, mem_rvalid_i, mem_awready_i, mem_wready_i, mem_bvalid_i;
  logic [1:0]  mem_bresp_i;
  logic        ifu_arready_o, ifu_rvalid_o, lsu_arready_o, lsu_rvalid_o;
  logic        lsu_awready_o, lsu_wready_o, lsu_bvalid_o;
  logic [31:0] ifu_rdata_o, lsu_rdata_o, mem_araddr_o, mem_awaddr_o, mem_wdata_o;
  logic [1:0]  lsu_bresp_o;
  logic        mem_arvalid_o, mem_rready_o, mem_awvalid_o, mem_wvalid_o, mem_bready_o;
  logic [3:0]  mem_wstrb_o;

  int total = 0;
  int bad   = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0;
  int b0, b1;

  mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_araddr_i(ifu_araddr_i), .ifu_arvalid_i(ifu_arvalid_i), .ifu_arready_o(ifu_arready_o),
    .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o), .ifu_rready_i(ifu_rready_i),
    .lsu_araddr_i(lsu_araddr_i), .lsu_arvalid_i(lsu_arvalid_i), .lsu_arready_o(lsu_arready_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rready_i(lsu_rready_i),
    .lsu_awaddr_i(lsu_awaddr_i), .lsu_awvalid_i(lsu_awvalid_i), .lsu_awready_o(lsu_awready_o),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i), .lsu_wvalid_i(lsu_wvalid_i),
    .lsu_wready_o(lsu_wready_o), .lsu_bresp_o(lsu_bresp_o), .lsu_bvalid_o(lsu_bvalid_o),
    .lsu_bready_i(lsu_bready_i),
    .mem_araddr_o(mem_araddr_o), .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .mem_awaddr_o(mem_awaddr_o), .mem_awvalid_o(mem_awvalid_o), .mem_awready_i(mem_awready_i),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_wvalid_o(mem_wvalid_o),
    .mem_wready_i(mem_wready_i), .mem_bresp_i(mem_bresp_i), .mem_bvalid_i(mem_bvalid_i),
    .mem_bready_o(mem_bready_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_arvalid_o && mem_arready_i) ar_hs <= ar_hs + 1;
    if (mem_awvalid_o && mem_awready_i) aw_hs <= aw_hs + 1;
    if (mem_wvalid_o && mem_wready_i)   w_hs  <= w_hs + 1;
  end

  typedef struct {
    logic        ifu_ar, lsu_ar, lsu_aw, lsu_w;
    logic        e_arv;
    logic [31:0] e_araddr;
    logic        e_awv, e_wv, e_ifu_rdy, e_lsu_rdy;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0; lsu_awvalid_i = 1'b0; lsu_wvalid_i = 1'b0;
    ifu_rready_i = 1'b0; lsu_rready_i = 1'b0; lsu_bready_i = 1'b0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_awready_i = 1'b0;
    mem_wready_i = 1'b0; mem_bvalid_i = 1'b0; mem_bresp_i = 2'b00;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, IFU_A, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, LSU_A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LSU_A, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};

    ifu_araddr_i = IFU_A; lsu_araddr_i = LSU_A; lsu_awaddr_i = WR_A;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wstrb_i = 4'b1100; mem_rdata_i = 32'h0;
    clear_inputs();
    rst_i = 1'b1;

    // reset: requests and slave readiness present, nothing may pass
    ifu_arvalid_i = 1'b1; lsu_awvalid_i = 1'b1; mem_arready_i = 1'b1; mem_awready_i = 1'b1;
    tick(); tick();
    chk("reset_outs", {mem_arvalid_o, mem_awvalid_o, mem_wvalid_o, ifu_arready_o, lsu_awready_o,
                       mem_rready_o, mem_bready_o}, 7'b0);
    clear_inputs();
    rst_i = 1'b0;
    tick();

    // arbitration table
    for (int i = 0; i < 8; i++) begin
      ifu_arvalid_i = vecs[i].ifu_ar; lsu_arvalid_i = vecs[i].lsu_ar;
      lsu_awvalid_i = vecs[i].lsu_aw; lsu_wvalid_i = vecs[i].lsu_w;
      mem_arready_i = 1'b1; mem_awready_i = 1'b1; mem_wready_i = 1'b1;
      #1;
      chk($sformatf("idle_quiet[%0d]", i),
          {mem_arvalid_o, mem_awvalid_o, mem_wvalid_o, ifu_arready_o, lsu_arready_o}, 5'b0);
      tick();
      chk($sformatf("grant[%0d]", i),
          {mem_arvalid_o, mem_awvalid_o, mem_wvalid_o, ifu_arready_o, lsu_arready_o},
          {vecs[i].e_arv, vecs[i].e_awv, vecs[i].e_wv, vecs[i].e_ifu_rdy, vecs[i].e_lsu_rdy});
      if (vecs[i].e_arv) chk($sformatf("araddr[%0d]", i), mem_araddr_o, vecs[i].e_araddr);
      tick();
      ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0; lsu_awvalid_i = 1'b0; lsu_wvalid_i = 1'b0;
      if (vecs[i].e_awv || vecs[i].e_wv) begin
        mem_bvalid_i = 1'b1; mem_bresp_i = 2'b10; lsu_bready_i = 1'b1;
        #1;
        chk($sformatf("bresp[%0d]", i), {lsu_bvalid_o, lsu_bresp_o, mem_bready_o}, 4'b1101);
        tick();
      end else if (vecs[i].e_arv) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5600 + i; ifu_rready_i = 1'b1; lsu_rready_i = 1'b1;
        #1;
        chk($sformatf("rvalid[%0d]", i), {ifu_rvalid_o, lsu_rvalid_o},
            {vecs[i].e_ifu_rdy, vecs[i].e_lsu_rdy});
        tick();
      end
      clear_inputs();
    end

    // IFU fetch, slave arready after 2 cycles
    ifu_arvalid_i = 1'b1;
    tick();
    chk("ifu_arvalid", {mem_arvalid_o, ifu_arready_o}, 2'b10);
    chk("ifu_araddr", mem_araddr_o, IFU_A);
    tick(); tick();
    mem_arready_i = 1'b1;
    #1;
    chk("ifu_arready", ifu_arready_o, 1'b1);
    tick();
    ifu_arvalid_i = 1'b0; mem_arready_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0413; ifu_rready_i = 1'b1;
    #1;
    chk("ifu_rdata", {ifu_rvalid_o, lsu_rvalid_o, ifu_rdata_o}, {2'b10, 32'h0000_0413});
    tick();
    chk("stray_rvalid_ignored", {ifu_rvalid_o, mem_rready_o}, 2'b00);
    tick();
    clear_inputs();
    chk("stray_rvalid_no_grant", mem_arvalid_o, 1'b0);

    // simultaneous IFU/LSU reads: LSU first, IFU after
    ifu_arvalid_i = 1'b1; lsu_arvalid_i = 1'b1; mem_arready_i = 1'b1;
    tick();
    chk("dual_lsu_first", {mem_araddr_o, lsu_arready_o, ifu_arready_o}, {LSU_A, 2'b10});
    tick();
    lsu_arvalid_i = 1'b0; mem_arready_i = 1'b0;
    mem_rvalid_i = 1'b1; lsu_rready_i = 1'b1;
    #1;
    chk("dual_lsu_r", {lsu_rvalid_o, ifu_rvalid_o, ifu_arready_o}, 3'b100);
    tick();
    mem_rvalid_i = 1'b0; lsu_rready_i = 1'b0;
    #1;
    chk("dual_idle_gap", mem_arvalid_o, 1'b0);
    tick();
    chk("dual_ifu_next", {mem_arvalid_o, mem_araddr_o}, {1'b1, IFU_A});
    mem_arready_i = 1'b1;
    tick();
    ifu_arvalid_i = 1'b0; mem_arready_i = 1'b0; mem_rvalid_i = 1'b1; ifu_rready_i = 1'b1;
    tick();
    clear_inputs();

    // store: w accepted 3 cycles before aw, master holds wvalid
    b0 = aw_hs; b1 = w_hs;
    lsu_awvalid_i = 1'b1; lsu_wvalid_i = 1'b1; mem_wready_i = 1'b1;
    tick();
    chk("st_w_fwd", {mem_wvalid_o, lsu_wready_o, mem_wdata_o, mem_wstrb_o},
        {2'b11, 32'hDEAD_BEEF, 4'b1100});
    tick();
    chk("st_w_done", {mem_wvalid_o, lsu_wready_o, mem_awvalid_o}, 3'b001);
    tick(); tick();
    mem_awready_i = 1'b1;
    #1;
    chk("st_aw_fwd", {mem_awvalid_o, lsu_awready_o, mem_awaddr_o}, {2'b11, WR_A});
    tick();
    lsu_awvalid_i = 1'b0; lsu_wvalid_i = 1'b0;
    mem_bvalid_i = 1'b1; mem_bresp_i = 2'b00; lsu_bready_i = 1'b1;
    #1;
    chk("st_bresp", {lsu_bvalid_o, lsu_bresp_o}, 3'b100);
    tick();
    clear_inputs();
    chk("st_hs_counts", {aw_hs - b0, w_hs - b1}, {32'd1, 32'd1});

    // LSU holds arvalid through 5-cycle slave latency
    b0 = ar_hs;
    lsu_arvalid_i = 1'b1; mem_arready_i = 1'b1; lsu_rready_i = 1'b1;
    tick();
    tick();
    chk("hold_ar_blocked", {mem_arvalid_o, lsu_arready_o}, 2'b00);
    tick(); tick(); tick();
    mem_rvalid_i = 1'b1;
    #1;
    chk("hold_rvalid", lsu_rvalid_o, 1'b1);
    tick();
    clear_inputs();
    tick();
    chk("hold_ar_hs", ar_hs - b0, 1);

    // reset mid-write with aw already accepted
    lsu_awvalid_i = 1'b1; lsu_wvalid_i = 1'b1; mem_awready_i = 1'b1;
    tick();
    tick();
    chk("rst_pre_awdone", {mem_awvalid_o, mem_wvalid_o}, 2'b01);
    mem_bvalid_i = 1'b1; lsu_bready_i = 1'b1; mem_wready_i = 1'b1;
    rst_i = 1'b1;
    #1;
    chk("rst_async_outs", {mem_awvalid_o, mem_wvalid_o, lsu_awready_o, lsu_wready_o,
                           lsu_bvalid_o, mem_bready_o, mem_arvalid_o}, 7'b0);
    tick();
    mem_bvalid_i = 1'b0; lsu_bready_i = 1'b0; mem_wready_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("rst_idle_after", {mem_awvalid_o, mem_wvalid_o}, 2'b00);
    tick();
    chk("rst_rearb_aw", {mem_awvalid_o, lsu_awready_o, mem_wvalid_o}, 3'b111);
    mem_wready_i = 1'b1;
    tick();
    lsu_awvalid_i = 1'b0; lsu_wvalid_i = 1'b0;
    mem_bvalid_i = 1'b1; lsu_bready_i = 1'b1;
    tick();
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
